// File: rtl/ku040_clock_reset_pkg.sv
// ku040_clock_reset_pkg
// Shared definitions for the KU040 clock/reset controller.
//   state_t      : 2-bit FSM state encoding (legacy-compatible constants)
//   RETRY_WIDTH  : width of the saturating lock-timeout counter
//   max3()       : elaboration-time helper for sizing the shared counter

package ku040_clock_reset_pkg;

    typedef logic [1:0] state_t;

    localparam state_t MMCM_RST  = 2'd0;
    localparam state_t WAIT_LOCK = 2'd1;
    localparam state_t STABLE    = 2'd2;
    localparam state_t RUN       = 2'd3;

    localparam int unsigned RETRY_WIDTH = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ku040_sync_debounce.sv
// ku040_sync_debounce
// Multi-flop synchronizer with an optional saturating debounce counter.
// Ports:
//   clk_i     : sampling clock
//   rst_ni    : synchronous active-low reset; clears every flop
//   async_i   : asynchronous inputs (WIDTH bits)
//   sync_o    : synchronized copy of async_i, SYNC_STAGES clocks late
//   pressed_o : debounce counter saturated on sync_o[0] (0 when DEBOUNCE_EN=0)
// The counter only looks at bit 0; multi-bit instances are expected to run
// with DEBOUNCE_EN=0 and use the synchronizer path alone.

module ku040_sync_debounce #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter bit          DEBOUNCE_EN   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             pressed_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_EN) begin : g_debounce
        logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;

        // Any low sample restarts the count; holding keeps it pinned at all-ones.
        always_comb begin
            db_cnt_d = db_cnt_q;
            if (!sync_o[0]) begin
                db_cnt_d = '0;
            end else if (db_cnt_q != '1) begin
                db_cnt_d = db_cnt_q + DEBOUNCE_BITS'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_d;
            end
        end

        assign pressed_o = &db_cnt_q;
    end else begin : g_bypass
        assign pressed_o = 1'b0;
    end

endmodule

// File: rtl/ku040_clock_reset_ctrl.sv
// ku040_clock_reset_ctrl
// Brings up the board MMCMs from the free-running oscillator and produces the
// areset that feeds the downstream reset hold/sync chain.
// Sequence: pulse mmcm_reset, wait for every locked flag, require the locks to
// stay up for a qualification window, then release areset. Re-arms on loss of
// lock, on lock timeout, or on a debounced push-button press.
// Ports:
//   clock      : free-running board clock
//   resetn     : synchronous active-low reset
//   button     : asynchronous push-button, active-high
//   locked     : asynchronous MMCM/PLL locked flags (ANDed)
//   mmcm_reset : registered, drives MMCM RST pins
//   areset     : registered, active-high reset to the downstream hold
//   state      : current FSM state
//   retries    : saturating count of lock timeouts
//   lock_lost  : sticky, set when lock drops in RUN

module ku040_clock_reset_ctrl
    import ku040_clock_reset_pkg::*;
#(
    parameter int unsigned NUM_LOCKS         = 2,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned MMCM_RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT_BITS = 20,
    parameter int unsigned STABLE_BITS       = 8,
    parameter int unsigned BTN_DEBOUNCE_BITS = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   button,
    input  logic [NUM_LOCKS-1:0]   locked,
    output logic                   mmcm_reset,
    output logic                   areset,
    output logic [1:0]             state,
    output logic [RETRY_WIDTH-1:0] retries,
    output logic                   lock_lost
);

    // One counter is shared by all timed states, so it is sized for the longest.
    localparam int unsigned CNT_W = max3(LOCK_TIMEOUT_BITS, STABLE_BITS,
                                         $clog2(MMCM_RST_CYCLES));

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((64'd1 << LOCK_TIMEOUT_BITS) - 64'd1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((64'd1 << STABLE_BITS) - 64'd1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_LOCKS-1:0] lock_sync;
    logic                 all_locked;
    logic                 btn_pressed;
    logic                 unused_lock_pressed;
    logic                 unused_btn_sync;

    ku040_sync_debounce #(
        .WIDTH         (NUM_LOCKS),
        .SYNC_STAGES   (SYNC_STAGES),
        .DEBOUNCE_BITS (1),
        .DEBOUNCE_EN   (1'b0)
    ) u_lock_sync (
        .clk_i     (clock),
        .rst_ni    (resetn),
        .async_i   (locked),
        .sync_o    (lock_sync),
        .pressed_o (unused_lock_pressed)
    );

    ku040_sync_debounce #(
        .WIDTH         (1),
        .SYNC_STAGES   (SYNC_STAGES),
        .DEBOUNCE_BITS (BTN_DEBOUNCE_BITS),
        .DEBOUNCE_EN   (1'b1)
    ) u_btn_debounce (
        .clk_i     (clock),
        .rst_ni    (resetn),
        .async_i   (button),
        .sync_o    (unused_btn_sync),
        .pressed_o (btn_pressed)
    );

    assign all_locked = &lock_sync;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_WIDTH-1:0] retries_q, retries_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   mmcm_reset_q, areset_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retries_d   = retries_q;
        lock_lost_d = lock_lost_q;

        if (btn_pressed) begin
            // Button wins over everything; the reset pulse is timed from release.
            state_d = MMCM_RST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                MMCM_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (all_locked) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = MMCM_RST;
                        cnt_d   = '0;
                        if (retries_q != '1) begin
                            retries_d = retries_q + RETRY_WIDTH'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!all_locked) begin
                        // Qualification restarts from zero; not counted as a retry.
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!all_locked) begin
                        state_d     = MMCM_RST;
                        cnt_d       = '0;
                        lock_lost_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from state_d so they move on the same edge as state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= MMCM_RST;
            cnt_q        <= '0;
            retries_q    <= '0;
            lock_lost_q  <= 1'b0;
            mmcm_reset_q <= 1'b1;
            areset_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retries_q    <= retries_d;
            lock_lost_q  <= lock_lost_d;
            mmcm_reset_q <= (state_d == MMCM_RST);
            areset_q     <= (state_d != RUN);
        end
    end

    assign state      = state_q;
    assign retries    = retries_q;
    assign lock_lost  = lock_lost_q;
    assign mmcm_reset = mmcm_reset_q;
    assign areset     = areset_q;

endmodule

// File: doc/ku040_clock_reset_ctrl.md
Name: ku040_clock_reset_ctrl

Overview:
- Upstream companion of the KU040 reset hold/sync chain. Produces the `areset` that feeds it.
- Runs on the free-running board oscillator.
- Pulses the MMCM reset and waits for every `locked` to assert.
- Requires the locks to stay stable for a qualification window before releasing `areset`.
- Re-arms on loss of lock, on lock timeout, or on a debounced push-button press.

Parameters:
- NUM_LOCKS, 2, number of MMCM/PLL locked inputs that are ANDed.
- SYNC_STAGES, 2, synchronizer depth for `locked` and `button` (minimum 2).
- MMCM_RST_CYCLES, 16, width of the `mmcm_reset` pulse in clocks (minimum 1).
- LOCK_TIMEOUT_BITS, 20, WAIT_LOCK gives up after 2^LOCK_TIMEOUT_BITS clocks.
- STABLE_BITS, 8, locks must hold for 2^STABLE_BITS clocks before release.
- BTN_DEBOUNCE_BITS, 16, button must be high for 2^BTN_DEBOUNCE_BITS - 1 consecutive clocks.

Ports:
- clock, in, 1, free-running board clock.
- resetn, in, 1, reset; one clock; synchronous, active-low.
- button, in, 1, asynchronous push-button; active-high.
- locked, in, NUM_LOCKS, asynchronous MMCM locked flags.
- mmcm_reset, out, 1, registered; drives the MMCM RST pins.
- areset, out, 1, registered; active-high; feeds the downstream reset hold.
- state, out, 2, current FSM state.
- retries, out, 8, saturating count of lock timeouts.
- lock_lost, out, 1, sticky; set when lock drops in RUN.

Behaviour:
Reset (resetn low at posedge):
- state=MMCM_RST; cnt=0.
- mmcm_reset=1, areset=1, retries=0, lock_lost=0.
- All synchronizer flops=0; debounce counter=0.

Input conditioning:
- `locked` and `button` each pass through SYNC_STAGES flops.
- all_locked = AND of the synchronized locks.
- Debounce counter: increments while the synchronized button is high, saturating at 2^BTN_DEBOUNCE_BITS - 1; clears when it is low.
- btn_pressed = counter saturated. It stays asserted while the button is held.

States (encoding 0..3) and shared counter cnt, width max(LOCK_TIMEOUT_BITS, STABLE_BITS, clog2(MMCM_RST_CYCLES)):
- MMCM_RST (0): mmcm_reset=1, areset=1.
  - cnt increments.
  - When cnt == MMCM_RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- WAIT_LOCK (1): mmcm_reset=0, areset=1.
  - If all_locked: go to STABLE, cnt=0.
  - Else if cnt == 2^LOCK_TIMEOUT_BITS - 1: go to MMCM_RST, cnt=0, retries increments (saturating at 255).
  - Else cnt increments.
- STABLE (2): mmcm_reset=0, areset=1.
  - If !all_locked: go to WAIT_LOCK, cnt=0, no retry increment.
  - Else if cnt == 2^STABLE_BITS - 1: go to RUN.
  - Else cnt increments.
- RUN (3): mmcm_reset=0, areset=0.
  - If !all_locked: go to MMCM_RST, cnt=0, lock_lost=1.

Priority and output timing:
- btn_pressed overrides every transition: go to (or stay in) MMCM_RST with cnt held at 0. retries and lock_lost are untouched.
- Holding the button therefore keeps mmcm_reset asserted. The MMCM_RST_CYCLES count starts at btn_pressed deassertion.
- mmcm_reset and areset are registered from the next-state decode, so they change on the same edge as `state`.
- Release latency with locks already stable at the pins: areset falls SYNC_STAGES + 1 + 2^STABLE_BITS clocks after the first WAIT_LOCK cycle in which the pin-level lock is present (±1).
- Lock glitch shorter than one clock and not captured by the synchronizer: no effect.
- Any captured drop during STABLE restarts qualification from zero.
- lock_lost clears only on resetn.

Decomposition:
- Shared package ku040_clock_reset_pkg holds:
  - state typedef and encodings MMCM_RST=2'd0, WAIT_LOCK=2'd1, STABLE=2'd2, RUN=2'd3;
  - RETRY_WIDTH=8.
- One sub-module, ku040_sync_debounce: SYNC_STAGES synchronizer plus saturating debounce counter, parameterized by width and bits.
  - Instantiated once for the button.
  - Locks use the synchronizer path only (debounce bypass parameter).

Test Plan:
Bench parameters: SYNC_STAGES=2, MMCM_RST_CYCLES=4, LOCK_TIMEOUT_BITS=4, STABLE_BITS=3, BTN_DEBOUNCE_BITS=2, NUM_LOCKS=2.
1. Normal bring-up: resetn low 3 clocks, then high; locked=2'b11 asserted 2 clocks after WAIT_LOCK is entered.
   - mmcm_reset high exactly 4 clocks.
   - areset falls 8 clocks after STABLE entry; state reads 3.
2. Partial lock: locked=2'b01 held permanently.
   - After WAIT_LOCK expires (16 clocks), state returns to MMCM_RST and retries=1.
   - Drive 300 timeouts; retries saturates at 255 and does not wrap.
3. Glitch during STABLE: locked drops to 2'b10 for 1 clock at STABLE cnt=5.
   - State goes to WAIT_LOCK; retries unchanged.
   - areset stays 1 until a fresh 8-clock window completes.
4. Loss in RUN: drop locked[1] in RUN.
   - Within 3 clocks areset=1, mmcm_reset=1, lock_lost=1.
   - Relock; lock_lost stays 1 after RUN is re-entered.
5. Button:
   - 2-clock pulse: no effect.
   - 10-clock hold in RUN: enters MMCM_RST after 5 clocks (2 sync + 3 debounce); mmcm_reset stays high until 4 clocks after the button's synchronized release.
6. resetn mid-operation: assert resetn in STABLE at cnt=4.
   - Next edge: state=0, mmcm_reset=1, areset=1, retries=0, lock_lost=0.
